// File: rtl/inst_issue_fifo_pkg.sv
// Shared fetch/decode definitions: the fetch entry record and the issue buffer depth.
package inst_issue_fifo_pkg;

   localparam int INST_FIFO_DEPTH = 16;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        excp;
   } fetch_entry_t;

endpackage

// File: rtl/inst_fifo_mem.sv
// Instruction buffer storage: DEPTH fetch entries, two write ports, two asynchronous read ports.
module inst_fifo_mem
   import inst_issue_fifo_pkg::*;
#(
   parameter int DEPTH = INST_FIFO_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we0,
   input  logic [PTR_W-1:0] wa0,
   input  fetch_entry_t     wd0,
   input  logic             we1,
   input  logic [PTR_W-1:0] wa1,
   input  fetch_entry_t     wd1,
   input  logic [PTR_W-1:0] ra0,
   input  logic [PTR_W-1:0] ra1,
   output fetch_entry_t     rd0,
   output fetch_entry_t     rd1
);

   // No reset: contents are only observable through valid-qualified read logic.
   fetch_entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we0) mem[wa0] <= wd0;
      if (we1) mem[wa1] <= wd1;
   end

   assign rd0 = mem[ra0];
   assign rd1 = mem[ra1];

endmodule

// File: rtl/inst_issue_fifo.sv
// Dual-write / dual-read instruction buffer between fetch and dual-issue decode.
module inst_issue_fifo
   import inst_issue_fifo_pkg::*;
#(
   parameter int DEPTH = INST_FIFO_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             wr_en0,
   input  logic             wr_en1,
   input  logic [31:0]      wr_pc0,
   input  logic [31:0]      wr_pc1,
   input  logic [31:0]      wr_inst0,
   input  logic [31:0]      wr_inst1,
   input  logic             wr_excp0,
   input  logic             wr_excp1,
   input  logic             rd_en_master,
   input  logic             rd_en_slave,
   output logic             rd_valid_master,
   output logic             rd_valid_slave,
   output logic [31:0]      rd_pc_master,
   output logic [31:0]      rd_pc_slave,
   output logic [31:0]      rd_inst_master,
   output logic [31:0]      rd_inst_slave,
   output logic             rd_excp_master,
   output logic             rd_excp_slave,
   output logic             fifo_empty,
   output logic             fifo_almost_empty,
   output logic             fifo_full,
   output logic [PTR_W:0]   count
);

   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [1:0]       n_wr_req;
   logic [1:0]       n_wr;
   logic [1:0]       n_rd_req;
   logic [1:0]       n_rd;
   logic             we0;
   logic             we1;
   fetch_entry_t     wd0;
   fetch_entry_t     wd1;
   fetch_entry_t     ent_master;
   fetch_entry_t     ent_slave;

   // Push acceptance looks only at start-of-cycle full; a same-cycle pop never frees room.
   always_comb begin
      n_wr_req = {wr_en0 & wr_en1, wr_en0 & ~wr_en1};
      n_rd_req = {rd_en_master & rd_en_slave, rd_en_master & ~rd_en_slave};
      n_wr     = fifo_full ? 2'd0 : n_wr_req;
      n_rd     = ((PTR_W+1)'(n_rd_req) > count) ? count[1:0] : n_rd_req;
      we0      = n_wr != 2'd0 && !flush;
      we1      = n_wr == 2'd2 && !flush;
      wd0      = '{pc: wr_pc0, inst: wr_inst0, excp: wr_excp0};
      wd1      = '{pc: wr_pc1, inst: wr_inst1, excp: wr_excp1};
   end

   inst_fifo_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
      .clk (clk),
      .we0 (we0),
      .wa0 (wr_ptr),
      .wd0 (wd0),
      .we1 (we1),
      .wa1 (wr_ptr + PTR_W'(1)),
      .wd1 (wd1),
      .ra0 (rd_ptr),
      .ra1 (rd_ptr + PTR_W'(1)),
      .rd0 (ent_master),
      .rd1 (ent_slave)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(n_wr);
         rd_ptr <= rd_ptr + PTR_W'(n_rd);
         count  <= count + (PTR_W+1)'(n_wr) - (PTR_W+1)'(n_rd);
      end
   end

   // Full at DEPTH-1 so a two-wide push always fits once accepted.
   assign fifo_empty        = count == '0;
   assign fifo_almost_empty = count == (PTR_W+1)'(1);
   assign fifo_full         = count >= DEPTH_C - (PTR_W+1)'(1);

   assign rd_valid_master = count >= (PTR_W+1)'(1);
   assign rd_valid_slave  = count >= (PTR_W+1)'(2);
   assign rd_pc_master    = rd_valid_master ? ent_master.pc   : '0;
   assign rd_inst_master  = rd_valid_master ? ent_master.inst : '0;
   assign rd_excp_master  = rd_valid_master & ent_master.excp;
   assign rd_pc_slave     = rd_valid_slave  ? ent_slave.pc    : '0;
   assign rd_inst_slave   = rd_valid_slave  ? ent_slave.inst  : '0;
   assign rd_excp_slave   = rd_valid_slave  & ent_slave.excp;

   a_count_bound: assert property (@(posedge clk) disable iff (!resetn) count <= DEPTH_C);
   a_no_push_full: assert property (@(posedge clk) disable iff (!resetn) we0 |-> !fifo_full);

endmodule

// File: doc/inst_issue_fifo.md
Name: inst_issue_fifo

Overview:
- Dual-write, dual-read instruction buffer between the fetch stage and the dual-issue decode stage.
- Fetch pushes 0/1/2 instructions per cycle. Decode pops the head (master slot) and optionally head+1 (slave slot).
- Generates the fifo_empty / fifo_almost_empty status that the issue controller uses to gate slave issue, and the full back-pressure that stalls fetch.
- Flushed on branch redirect or exception.

Parameters:
- DEPTH, 16, number of entries; must be a power of two and at least 4.
- PTR_W, $clog2(DEPTH), read/write pointer width.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  discard all entries (redirect or exception).
- wr_en0  in  1  push fetch slot 0.
- wr_en1  in  1  push fetch slot 1; legal only with wr_en0=1.
- wr_pc0, wr_pc1  in  32 each  PC of each fetch slot.
- wr_inst0, wr_inst1  in  32 each  instruction word of each fetch slot.
- wr_excp0, wr_excp1  in  1 each  fetch address-error flag of each slot.
- rd_en_master  in  1  decode consumes the head entry.
- rd_en_slave  in  1  decode consumes head+1; honoured only with rd_en_master=1.
- rd_valid_master, rd_valid_slave  out  1 each  head / head+1 entry present.
- rd_pc_master, rd_pc_slave  out  32 each  PC of head / head+1.
- rd_inst_master, rd_inst_slave  out  32 each  instruction of head / head+1.
- rd_excp_master, rd_excp_slave  out  1 each  exception flag of head / head+1.
- fifo_empty  out  1  count==0.
- fifo_almost_empty  out  1  count==1.
- fifo_full  out  1  free slots < 2; fetch must stall.
- count  out  PTR_W+1  current occupancy.

Behaviour:
- Reset (async, resetn=0):
  - wr_ptr=rd_ptr=count=0.
  - fifo_empty=1; fifo_almost_empty=0; fifo_full=0.
  - Both rd_valid=0; all rd_* data=0.
  - Storage contents are don't-care.
  - Reset mid-operation discards everything immediately, with no partial pop or push.
- Read outputs are combinational from storage and pointers:
  - master slot = mem[rd_ptr]; slave slot = mem[rd_ptr+1], modulo DEPTH.
  - rd_valid_master = count>=1; rd_valid_slave = count>=2.
  - Whenever a slot is not valid, its pc/inst/excp read as 0.
- Push count per cycle: n_wr = wr_en0 + (wr_en0 & wr_en1). wr_en1 without wr_en0 is ignored (n_wr=0).
- Push acceptance is decided from start-of-cycle fifo_full only.
  - If fifo_full=1, the whole push is dropped, all-or-nothing. Fetch is responsible for holding.
  - A pop in the same cycle does not enable the push.
- Pop count per cycle: n_rd = rd_en_master + (rd_en_master & rd_en_slave), clamped to the current count.
  - Popping an empty FIFO is a no-op.
  - rd_en_slave alone is ignored.
- Storage write:
  - slot 0 goes to mem[wr_ptr]; slot 1 goes to mem[wr_ptr+1], modulo DEPTH.
  - Pointers advance by n_wr / n_rd and wrap naturally at PTR_W bits.
- Next occupancy: count_next = count + n_wr_accepted - n_rd.
  - Never exceeds DEPTH. Never goes below 0.
- No write-to-read bypass: a pushed entry is first visible the cycle after the push.
  - Consequence: on an empty FIFO, push and pop in the same cycle gives pop no-op, push accepted.
- Flush has priority over everything in its cycle.
  - Same-cycle pushes and pops are discarded.
  - Next cycle: pointers=0, count=0, fifo_empty=1.
- Status flags (fifo_empty, fifo_almost_empty, fifo_full) are combinational from registered count.
  - They are therefore stable throughout the cycle.
- Wrap-around: a 2-entry push or pop straddling index DEPTH-1 → 0 must split correctly.
  - Example: wr_ptr=DEPTH-1 writes slot 0 to mem[DEPTH-1] and slot 1 to mem[0].
- Full boundary: count=DEPTH-1 asserts fifo_full, even though one slot remains free.
  - This guarantees a 2-wide push always fits.
- Assertions for verification:
  - count <= DEPTH at all times.
  - No accepted push while fifo_full=1.

Decomposition:
- Shared package (the core's existing defines package):
  - fetch_entry_t struct {pc[31:0], inst[31:0], excp}.
  - INST_FIFO_DEPTH constant, consumed by fetch and decode.
- One natural sub-module: inst_fifo_mem.
  - DEPTH x fetch_entry_t register array.
  - Two write ports (addr, data, en) and two asynchronous read ports.
  - Keeps pointer/count control separate and allows later swap to LUTRAM.

Test Plan:
- Reset then idle → fifo_empty=1, count=0, both rd_valid=0, rd_inst_master=0.
- Dual push (pc 0x1000 / 0x1004) at cycle 1, no pop:
  - cycle 2 shows count=2, master pc=0x1000, slave pc=0x1004, almost_empty=0.
  - Dual pop at cycle 2 → cycle 3 shows fifo_empty=1.
- Fill with 15 single pushes (DEPTH=16) → fifo_full=1. A further dual push with no pop is dropped: count stays 15, wr_ptr unchanged.
- Wrap test:
  - Set pointers to 15 by pushing and popping 15 entries.
  - Dual push pc 0x2000/0x2004 lands in mem[15]/mem[0].
  - Next cycle master=0x2000, slave=0x2004.
- Simultaneous flush + dual push + dual pop at count=5 → next cycle count=0, fifo_empty=1, no new entries visible.
- With count=1: rd_en_master=1, rd_en_slave=1 → pops only 1, count=0.
  - rd_en_slave=1 alone at count=3 → no pop, count stays 3.
- Async reset asserted mid-cycle with count=7 → outputs return to reset values before the next clk edge.
